// File: rtl/hmi_setpoint_ctrl.sv
// Front-panel HMI: key debounce/auto-repeat, clamped setpoint, sequential BCD conversion, muxed 7-seg scan.
// Latency: setpoint updates 1 cycle after a key event; bcd follows a setpoint change by VAL_W+3 cycles.
// No backpressure: a setpoint change during a conversion is queued and converted once the current one ends.
module hmi_setpoint_ctrl #(
    parameter int VAL_W        = 10,
    parameter int VAL_MIN      = 0,
    parameter int VAL_MAX      = 999,
    parameter int VAL_INIT     = 50,
    parameter int DIGITS       = 4,
    parameter int DEB_MS       = 20,
    parameter int REP_DELAY_MS = 500,
    parameter int REP_RATE_MS  = 100
) (
    input  logic                  clk_sys,
    input  logic                  rst_n,
    input  logic                  pluse_ms,
    input  logic [2:0]            key,
    output logic [VAL_W-1:0]      val,
    output logic [1:0]            step_sel,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  bcd_valid,
    output logic [7:0]            smg_data,
    output logic [DIGITS-1:0]     smg_scan
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int SR_W   = BCD_W + VAL_W;
    localparam int DEB_CW = $clog2(DEB_MS + 1);
    localparam int REP_CW = $clog2(REP_DELAY_MS + 1);
    localparam int EXT_W  = VAL_W + 8;
    localparam int CNT_W  = $clog2(VAL_W + 1);
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} cv_state_t;

    logic [2:0]             key_meta;
    logic [2:0]             key_sync;
    logic [2:0]             deb_lvl;
    logic [2:0][DEB_CW-1:0] deb_cnt;
    logic [2:0]             press;
    logic [1:0][REP_CW-1:0] rep_cnt;
    logic [1:0]             rep;
    logic                   up_ev;
    logic                   dn_ev;
    logic [EXT_W-1:0]       step_ext;
    logic [EXT_W-1:0]       val_ext;
    logic [EXT_W-1:0]       sum_ext;
    logic [EXT_W-1:0]       floor_ext;
    logic [VAL_W-1:0]       val_nxt;
    logic [1:0]             step_nxt;
    logic                   pending;
    cv_state_t              state;
    cv_state_t              state_nxt;
    logic [SR_W-1:0]        sr;
    logic [SR_W-1:0]        sr_adj;
    logic [SR_W-1:0]        sr_step;
    logic [CNT_W-1:0]       sh_cnt;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       idx_nxt;
    logic [IDX_W-1:0]       msd;
    logic [3:0]             nib;
    logic [6:0]             seg_on;
    logic [7:0]             data_nxt;

    // Two-flop synchroniser; keys idle high so reset to 1.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            key_meta <= 3'b111;
            key_sync <= 3'b111;
        end else begin
            key_meta <= key;
            key_sync <= key_meta;
        end
    end

    // Debounce: level flips on the DEB_MS-th consecutive differing ms sample; a 1->0 flip is a press.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            deb_lvl <= 3'b111;
            deb_cnt <= '0;
            press   <= '0;
        end else begin
            press <= '0;
            if (pluse_ms) begin
                for (int k = 0; k < 3; k++) begin
                    if (key_sync[k] == deb_lvl[k]) begin
                        deb_cnt[k] <= '0;
                    end else if (deb_cnt[k] == DEB_CW'(DEB_MS - 1)) begin
                        deb_lvl[k] <= key_sync[k];
                        deb_cnt[k] <= '0;
                        press[k]   <= ~key_sync[k];
                    end else begin
                        deb_cnt[k] <= deb_cnt[k] + 1'b1;
                    end
                end
            end
        end
    end

    // Auto-repeat for up/down: count ms held since press; after the first repeat, rewind by one period.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt <= '0;
            rep     <= '0;
        end else begin
            rep <= '0;
            for (int k = 0; k < 2; k++) begin
                if (deb_lvl[k]) begin
                    rep_cnt[k] <= '0;
                end else if (pluse_ms) begin
                    if (rep_cnt[k] == REP_CW'(REP_DELAY_MS - 1)) begin
                        rep[k]     <= 1'b1;
                        rep_cnt[k] <= REP_CW'(REP_DELAY_MS - REP_RATE_MS);
                    end else begin
                        rep_cnt[k] <= rep_cnt[k] + 1'b1;
                    end
                end
            end
        end
    end

    assign up_ev = press[0] | rep[0];
    assign dn_ev = press[1] | rep[1];

    // Clamped adjust in a widened domain so neither overflow nor underflow can wrap.
    always_comb begin
        case (step_sel)
            2'd1:    step_ext = EXT_W'(10);
            2'd2:    step_ext = EXT_W'(100);
            default: step_ext = EXT_W'(1);
        endcase
        val_ext   = EXT_W'(val);
        sum_ext   = val_ext + step_ext;
        floor_ext = EXT_W'(VAL_MIN) + step_ext;
        val_nxt   = val;
        if (up_ev && !dn_ev) begin
            val_nxt = (sum_ext > EXT_W'(VAL_MAX)) ? VAL_W'(VAL_MAX) : sum_ext[VAL_W-1:0];
        end else if (dn_ev && !up_ev) begin
            val_nxt = (val_ext < floor_ext) ? VAL_W'(VAL_MIN) : VAL_W'(val_ext - step_ext);
        end
    end

    // Step cycling; x100 only offered when the range can reach it.
    always_comb begin
        step_nxt = step_sel;
        if (press[2]) begin
            case (step_sel)
                2'd0:    step_nxt = 2'd1;
                2'd1:    step_nxt = (VAL_MAX >= 100) ? 2'd2 : 2'd0;
                default: step_nxt = 2'd0;
            endcase
        end
    end

    // Setpoint and step registers; adjust above already used the old step_sel.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            val      <= VAL_W'(VAL_INIT);
            step_sel <= 2'd0;
        end else begin
            val      <= val_nxt;
            step_sel <= step_nxt;
        end
    end

    // Converter state register.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Converter next state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pending) state_nxt = LOAD;
            LOAD:    state_nxt = SHIFT;
            SHIFT:   if (sh_cnt == CNT_W'(VAL_W - 1)) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
    always_comb begin
        sr_adj = sr;
        for (int i = 0; i < DIGITS; i++) begin
            if (sr_adj[VAL_W+4*i +: 4] >= 4'd5)
                sr_adj[VAL_W+4*i +: 4] = sr_adj[VAL_W+4*i +: 4] + 4'd3;
        end
        sr_step = sr_adj << 1;
    end

    // Converter datapath; a change landing on the LOAD cycle keeps pending set so it reruns.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= 1'b1;
            sr        <= '0;
            sh_cnt    <= '0;
            bcd       <= '0;
            bcd_valid <= 1'b0;
        end else begin
            if (val_nxt != val)    pending <= 1'b1;
            else if (state == LOAD) pending <= 1'b0;
            case (state)
                LOAD: begin
                    sr     <= {{BCD_W{1'b0}}, val};
                    sh_cnt <= '0;
                end
                SHIFT: begin
                    sr     <= sr_step;
                    sh_cnt <= sh_cnt + 1'b1;
                end
                DONE: begin
                    bcd       <= sr[SR_W-1:VAL_W];
                    bcd_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Display next digit: index, leading-zero blanking, segment decode, dp.
    always_comb begin
        idx_nxt = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
        msd = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] != 4'd0) msd = IDX_W'(i);
        end
        nib = bcd[{idx_nxt, 2'b00} +: 4];
        case (nib)
            4'd0:    seg_on = 7'h3F;
            4'd1:    seg_on = 7'h06;
            4'd2:    seg_on = 7'h5B;
            4'd3:    seg_on = 7'h4F;
            4'd4:    seg_on = 7'h66;
            4'd5:    seg_on = 7'h6D;
            4'd6:    seg_on = 7'h7D;
            4'd7:    seg_on = 7'h07;
            4'd8:    seg_on = 7'h7F;
            4'd9:    seg_on = 7'h6F;
            default: seg_on = 7'h00;
        endcase
        if (!bcd_valid) begin
            data_nxt = 8'hFF;
        end else begin
            data_nxt[7]   = ~(32'(idx_nxt) == 32'(step_sel));
            data_nxt[6:0] = (idx_nxt > msd) ? 7'h7F : ~seg_on;
        end
    end

    // Scan and segment registers move together on each ms tick so no digit ghosts.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            smg_scan <= ~DIGITS'(1);
            smg_data <= 8'hFF;
        end else if (pluse_ms) begin
            idx      <= idx_nxt;
            smg_scan <= ~(DIGITS'(1) << idx_nxt);
            smg_data <= data_nxt;
        end
    end

endmodule

// File: doc/hmi_setpoint_ctrl.md
Name: hmi_setpoint_ctrl

Overview:
- Parametrised next-generation HMI front end for the VFD board.
- Debounces N keys, adjusts a clamped setpoint with selectable step and auto-repeat, and converts the setpoint to BCD with a sequential double-dabble engine.
- Drives a DIGITS-wide multiplexed 7-segment display with leading-zero blanking and a step-indicator decimal point.
- Sits between the front-panel keys/display and the drive core; val feeds the frequency path.

Parameters:
- VAL_W, 10, setpoint width in bits.
- VAL_MIN, 0, lower clamp.
- VAL_MAX, 999, upper clamp; must be < 10^DIGITS and < 2^VAL_W.
- VAL_INIT, 50, reset setpoint.
- DIGITS, 4, display digits (BCD width 4*DIGITS).
- DEB_MS, 20, debounce stable count in ms ticks.
- REP_DELAY_MS, 500, hold time before auto-repeat starts.
- REP_RATE_MS, 100, auto-repeat period.

Ports:
- clk_sys  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- pluse_ms  in  1  one-clk_sys-wide pulse, once per ms.
- key  in  3  raw keys, active-low; [0]=up, [1]=down, [2]=step cycle.
- val  out  VAL_W  current setpoint.
- step_sel  out  2  0=x1, 1=x10, 2=x100.
- bcd  out  4*DIGITS  last completed BCD of val.
- bcd_valid  out  1  high once the first conversion completes.
- smg_data  out  8  active-low segments; [7]=dp, [6:0]=g..a.
- smg_scan  out  DIGITS  active-low one-hot digit select.

Behaviour:
- Reset (async, rst_n low):
  - val=VAL_INIT, step_sel=0, bcd=0, bcd_valid=0.
  - smg_data=8'hFF, smg_scan selects digit 0.
  - Conversion request pending.
- Key sync: 2-flop synchroniser per key.
- Debounce: sample on pluse_ms; a debounced level changes only after DEB_MS consecutive equal samples differing from it. A press is a debounced 1->0 transition, one clk_sys wide.
- Auto-repeat (up/down only): while debounced held, ms counter from press. First repeat at REP_DELAY_MS, then every REP_RATE_MS. Release clears the counter.
- Step key press: step_sel cycles 0->1->2->0. step_sel=2 is allowed only if VAL_MAX>=100, otherwise it wraps 1->0.
- Update, registered, one cycle after the event:
  - up: val=min(val+step, VAL_MAX).
  - down: val=max(val-step, VAL_MIN), computed without underflow (compare before subtract).
  - No wrap-around; at a limit, val holds.
- Simultaneous events:
  - up and down events in the same cycle: no change.
  - Step press coincident with up/down: the adjust uses the old step_sel; step_sel updates the same cycle.
- Converter FSM:
  - IDLE: a pending request triggers LOAD.
  - LOAD, 1 cycle: shift register = {0, val}.
  - SHIFT, VAL_W cycles: add-3 to each nibble >=5, then shift left 1.
  - DONE, 1 cycle: bcd latched, bcd_valid=1, back to IDLE.
  - Latency from the val update to bcd: VAL_W+3 cycles.
  - Any val change sets pending. A change during conversion does not abort it; it reruns after DONE. bcd always holds a coherent value.
- Display:
  - Scan index advances on each pluse_ms, wrapping DIGITS-1 -> 0. smg_scan and smg_data are registered together, with no ghosting between them.
  - Digits above the most significant nonzero digit are blanked (segments 1). Digit 0 always shows.
  - dp is lit on digit index step_sel.
  - smg_data stays 8'hFF while bcd_valid=0.
  - Segment codes are standard 0-9. Nibbles >9 cannot occur; if one does, show blank.
- Reset mid-conversion or mid-debounce: everything returns to reset values and a conversion restarts after release.

Test Plan:
- Release reset, no keys -> bcd_valid high within 14 cycles; bcd=16'h0050; digits 3..2 blank; digit 1 shows "5", digit 0 shows "0" with dp.
- key[0] bounces low/high every 3 ms for 15 ms, then held low 25 ms and released -> exactly one increment, val=51.
- Hold key[0] 1000 ms from val=50, step x1 -> val=51 at press, then repeats at 500, 600, …, 1000 ms -> val=57.
- Press step twice (x100), press up from 950 -> val=999. Press down at VAL_MIN=0 with val=30, step x100 -> val=0.
- Up and down debounced presses in the same cycle at val=200 -> val stays 200.
- Two up presses 5 cycles apart (second lands during conversion) -> bcd passes 0x0051 and ends 0x0052, with no intermediate corrupt value.
